// File: rtl/cmpr_stream_tracker.sv
// cmpr_stream_tracker: registered 4-bit magnitude-compare result behind a
// single-entry valid/ready stage, with saturating per-outcome event counters.
// Optional feature macro: CMPR_STREAK_EN adds a same-outcome streak detector
// and the streak_hit output port.
module cmpr_stream_tracker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned STREAK_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             alessb,
  output logic             aequalb,
  output logic             agreaterb,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] gt_cnt
`ifdef CMPR_STREAK_EN
  ,
  output logic             streak_hit
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic accept;
  logic cmp_lt;
  logic cmp_eq;
  logic cmp_gt;

  // Output register may take a new pair when empty or being drained; clr blocks intake
  always_comb begin
    in_ready = !clr && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    cmp_lt   = (a < b);
    cmp_eq   = (a == b);
    cmp_gt   = (a > b);
  end

  // Result register: load on accept, drop valid on pop, clr wins over both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alessb    <= 1'b0;
      aequalb   <= 1'b0;
      agreaterb <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      alessb    <= 1'b0;
      aequalb   <= 1'b0;
      agreaterb <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alessb    <= cmp_lt;
      aequalb   <= cmp_eq;
      agreaterb <= cmp_gt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating outcome counters, bumped at accept time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lt_cnt <= '0;
      eq_cnt <= '0;
      gt_cnt <= '0;
    end else if (clr) begin
      lt_cnt <= '0;
      eq_cnt <= '0;
      gt_cnt <= '0;
    end else if (accept) begin
      if (cmp_lt && (lt_cnt != CNT_MAX)) lt_cnt <= lt_cnt + CNT_W'(1);
      if (cmp_eq && (eq_cnt != CNT_MAX)) eq_cnt <= eq_cnt + CNT_W'(1);
      if (cmp_gt && (gt_cnt != CNT_MAX)) gt_cnt <= gt_cnt + CNT_W'(1);
    end
  end

`ifdef CMPR_STREAK_EN
  localparam int unsigned SW = $clog2(STREAK_LEN + 1);

  // Outcome code 0 means "no pair since reset/clr", so the first accept never matches
  localparam logic [1:0] OC_NONE = 2'd0;
  localparam logic [1:0] OC_LT   = 2'd1;
  localparam logic [1:0] OC_EQ   = 2'd2;
  localparam logic [1:0] OC_GT   = 2'd3;

  logic [1:0]    last_oc;
  logic [1:0]    cur_oc;
  logic [SW-1:0] streak;
  logic [SW-1:0] streak_nxt;

  // Encode this pair's outcome and the streak length it would produce
  always_comb begin
    cur_oc = OC_EQ;
    if (cmp_lt) cur_oc = OC_LT;
    if (cmp_gt) cur_oc = OC_GT;
    streak_nxt = SW'(1);
    if (cur_oc == last_oc) begin
      streak_nxt = (streak >= SW'(STREAK_LEN)) ? SW'(STREAK_LEN) : streak + SW'(1);
    end
  end

  // Streak state and registered hit flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_oc    <= OC_NONE;
      streak     <= '0;
      streak_hit <= 1'b0;
    end else if (clr) begin
      last_oc    <= OC_NONE;
      streak     <= '0;
      streak_hit <= 1'b0;
    end else if (accept) begin
      last_oc    <= cur_oc;
      streak     <= streak_nxt;
      streak_hit <= (streak_nxt >= SW'(STREAK_LEN));
    end
  end
`else
  // STREAK_LEN only matters when the streak detector is built
  if (STREAK_LEN == 0) begin : g_streak_len_unused
  end
`endif

endmodule
